// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
//   Shared constants for the register file: default geometry and the
//   encoding of the step direction carried on inc_dec.
// ----------------------------------------------------------------------------
package register_file_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Step direction as seen on the inc_dec pin.
    typedef enum logic {
        INC = 1'b0,
        DEC = 1'b1
    } step_dir_e;

endpackage : register_file_pkg

// File: rtl/register_cell.sv
// ----------------------------------------------------------------------------
// register_cell
//   One WIDTH-bit storage register with a load port and a +/-1 step port.
//   A load takes priority over a step issued in the same cycle.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-low clear
//     load       load enable
//     load_data  value written when load=1
//     step_en    step enable
//     step_dir   INC adds one, DEC subtracts one (modulo 2^WIDTH)
//     value      current register contents
// ----------------------------------------------------------------------------
module register_cell
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             step_en,
    input  step_dir_e        step_dir,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_next;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_next = value;
        if (load) begin
            value_next = load_data;
        end else if (step_en) begin
            // Plain modular arithmetic: wrap-around needs no special case.
            value_next = (step_dir == DEC) ? value - 1'b1 : value + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule : register_cell

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   DEPTH x WIDTH register file with one write port, one +/-1 step port and
//   two registered read ports. Reads see the post-update value of a register
//   being written or stepped at the same edge. A write and a step aimed at
//   the same register resolve in favour of the write and raise wr_conflict
//   for one cycle. With ZERO_R0=1 register 0 is hard-wired to zero.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     we           write enable
//     waddr/wdata  write address / data
//     inc_en       step enable
//     inc_addr     step target
//     inc_dec      step direction: 1 decrement, 0 increment
//     ra_addr      read port A address
//     rb_addr      read port B address
//     ra_data      registered read port A data
//     rb_data      registered read port B data
//     wr_conflict  previous cycle had we and inc_en on the same address
// ----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             inc_en,
    input  logic [AW-1:0]    inc_addr,
    input  logic             inc_dec,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             wr_conflict
);

    logic [DEPTH-1:0] load_sel;
    logic [DEPTH-1:0] step_sel;
    logic [WIDTH-1:0] values [DEPTH];
    step_dir_e        step_dir;
    logic             conflict_now;
    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;

    assign step_dir = step_dir_e'(inc_dec);

    // A conflict is reported even on register 0, where neither update lands.
    assign conflict_now = we && inc_en && (waddr == inc_addr);

    // ------------------------------------------------------------------
    // Address decode and storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit LOCKED = (ZERO_R0 != 0) && (i == 0);

        // Register 0 stays at its reset value of zero when locked.
        assign load_sel[i] = !LOCKED && we     && (waddr    == AW'(i));
        assign step_sel[i] = !LOCKED && inc_en && (inc_addr == AW'(i));

        register_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .load      (load_sel[i]),
            .load_data (wdata),
            .step_en   (step_sel[i]),
            .step_dir  (step_dir),
            .value     (values[i])
        );
    end

    // ------------------------------------------------------------------
    // Bypass: a read of a register being updated at this edge returns the
    // value that register will hold after the edge.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] post_update(
        input logic [WIDTH-1:0] current,
        input logic             load,
        input logic             step,
        input logic [WIDTH-1:0] load_data,
        input step_dir_e        dir
    );
        logic [WIDTH-1:0] result;
        result = current;
        if (load) begin
            result = load_data;
        end else if (step) begin
            result = (dir == DEC) ? current - 1'b1 : current + 1'b1;
        end
        return result;
    endfunction

    always_comb begin
        ra_next = post_update(values[ra_addr], load_sel[ra_addr],
                              step_sel[ra_addr], wdata, step_dir);
        rb_next = post_update(values[rb_addr], load_sel[rb_addr],
                              step_sel[rb_addr], wdata, step_dir);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // NOTE: every flop, storage and output alike, is cleared by the async
    // reset; the storage is individual registers rather than a RAM macro, so
    // a full clear is both possible and required.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra_data     <= '0;
            rb_data     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            ra_data     <= ra_next;
            rb_data     <= rb_next;
            wr_conflict <= conflict_now;
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file. Stimulus pushes hand-computed expected
//   read results into a scoreboard queue; a monitor on the falling edge pops
//   and compares them once the DUT has produced the corresponding output.
//   A second instance with ZERO_R0=0 shares all inputs.
// ----------------------------------------------------------------------------
module tb_register_file;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          inc_en;
    logic [AW-1:0] inc_addr;
    logic          inc_dec;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [W-1:0]  ra_data,    rb_data;
    logic          wr_conflict;
    logic [W-1:0]  nz_ra_data, nz_rb_data;
    logic          nz_wr_conflict;

    register_file #(.WIDTH(W), .DEPTH(8), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .inc_en(inc_en), .inc_addr(inc_addr), .inc_dec(inc_dec),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data), .wr_conflict(wr_conflict)
    );

    register_file #(.WIDTH(W), .DEPTH(8), .ZERO_R0(0)) dut_nz (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .inc_en(inc_en), .inc_addr(inc_addr), .inc_dec(inc_dec),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(nz_ra_data), .rb_data(nz_rb_data),
        .wr_conflict(nz_wr_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int           due;
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         chk_nz;
        logic [W-1:0] nz_a;
        logic [W-1:0] nz_b;
    } exp_t;

    exp_t sb[$];

    // Monitor: outputs for an operation issued before edge N are checked on
    // the falling edge following edge N.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " ra"}, ra_data, e.a);
            check({e.name, " rb"}, rb_data, e.b);
            check({e.name, " conflict"}, {15'd0, wr_conflict}, {15'd0, e.c});
            if (e.chk_nz) begin
                check({e.name, " nz ra"}, nz_ra_data, e.nz_a);
                check({e.name, " nz rb"}, nz_rb_data, e.nz_b);
                check({e.name, " nz conflict"}, {15'd0, nz_wr_conflict},
                      {15'd0, e.c});
            end
        end
    end

    // Drive one cycle of stimulus (called 2 ns after a rising edge), queue
    // its expected result, then advance past the next rising edge.
    task automatic issue(input string nm,
                         input logic w, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd,
                         input logic ie, input logic [AW-1:0] ia,
                         input logic id,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic ec,
                         input logic cnz, input logic [W-1:0] enza,
                         input logic [W-1:0] enzb);
        exp_t e;
        we = w;  waddr = wa;  wdata = wd;
        inc_en = ie;  inc_addr = ia;  inc_dec = id;
        ra_addr = a;  rb_addr = b;
        e.due = cyc + 1;  e.name = nm;
        e.a = ea;  e.b = eb;  e.c = ec;
        e.chk_nz = cnz;  e.nz_a = enza;  e.nz_b = enzb;
        sb.push_back(e);
        @(posedge clk);
        #2;
        we = 1'b0;
        inc_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0;  waddr = '0;  wdata = '0;
        inc_en = 1'b0;  inc_addr = '0;  inc_dec = 1'b0;
        ra_addr = '0;  rb_addr = '0;

        // Asynchronous reset, before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("reset ra", ra_data, 16'h0000);
        check("reset rb", rb_data, 16'h0000);
        check("reset conflict", {15'd0, wr_conflict}, 16'h0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            issue($sformatf("rd_all%0d", i), 0, 0, 0, 0, 0, 0,
                  AW'(i), AW'(7 - i), 16'h0000, 16'h0000, 0, 0, 0, 0);
        end

        // Write, then read on both ports; bypass on a fresh write.
        issue("wr_r3", 1, 3, 16'h1234, 0, 0, 0, 0, 0,
              16'h0000, 16'h0000, 0, 0, 0, 0);
        issue("rd_r3", 0, 0, 0, 0, 0, 0, 3, 3,
              16'h1234, 16'h1234, 0, 0, 0, 0);
        issue("byp_r5", 1, 5, 16'hBEEF, 0, 0, 0, 5, 3,
              16'hBEEF, 16'h1234, 0, 0, 0, 0);

        // Wrap-around in both directions, observed through the bypass.
        issue("wr_r2", 1, 2, 16'hFFFF, 0, 0, 0, 2, 5,
              16'hFFFF, 16'hBEEF, 0, 0, 0, 0);
        issue("inc_r2", 0, 0, 0, 1, 2, 0, 2, 2,
              16'h0000, 16'h0000, 0, 0, 0, 0);
        issue("dec_r2", 0, 0, 0, 1, 2, 1, 2, 2,
              16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        issue("hold_r2", 0, 0, 0, 0, 0, 0, 2, 5,
              16'hFFFF, 16'hBEEF, 0, 0, 0, 0);

        // Write/step collisions.
        issue("wr_r6", 1, 6, 16'h0009, 0, 0, 0, 6, 6,
              16'h0009, 16'h0009, 0, 0, 0, 0);
        issue("clash_r4", 1, 4, 16'h5678, 1, 4, 0, 4, 4,
              16'h5678, 16'h5678, 1, 0, 0, 0);
        issue("split_r4_r6", 1, 4, 16'h5678, 1, 6, 0, 4, 6,
              16'h5678, 16'h000A, 0, 0, 0, 0);
        issue("rd_r6_r4", 0, 0, 0, 0, 0, 0, 6, 4,
              16'h000A, 16'h5678, 0, 0, 0, 0);

        // Register 0: locked in dut, ordinary in dut_nz.
        issue("wr_r0", 1, 0, 16'hDEF0, 0, 0, 0, 0, 0,
              16'h0000, 16'h0000, 0, 1, 16'hDEF0, 16'hDEF0);
        issue("rd_r0", 0, 0, 0, 0, 0, 0, 0, 3,
              16'h0000, 16'h1234, 0, 1, 16'hDEF0, 16'h1234);
        issue("clash_r0", 1, 0, 16'hDEF0, 1, 0, 1, 0, 0,
              16'h0000, 16'h0000, 1, 1, 16'hDEF0, 16'hDEF0);
        issue("inc_r0", 0, 0, 0, 1, 0, 0, 0, 0,
              16'h0000, 16'h0000, 0, 1, 16'hDEF1, 16'hDEF1);

        // Idle cycles leave contents untouched.
        repeat (5) @(posedge clk);
        #2;
        issue("hold_r3_r5", 0, 0, 0, 0, 0, 0, 3, 5,
              16'h1234, 16'hBEEF, 0, 0, 0, 0);

        // Reset in the middle of a write.
        issue("wr_r1", 1, 1, 16'h9ABC, 0, 0, 0, 1, 1,
              16'h9ABC, 16'h9ABC, 0, 0, 0, 0);
        drain();
        we = 1'b1;  waddr = 1;  wdata = 16'h1111;
        ra_addr = 1;  rb_addr = 3;
        #1 rst = 1'b0;
        #1;
        check("midrst ra", ra_data, 16'h0000);
        check("midrst rb", rb_data, 16'h0000);
        check("midrst nz ra", nz_ra_data, 16'h0000);
        @(posedge clk);
        #2;
        check("inrst ra", ra_data, 16'h0000);
        check("inrst rb", rb_data, 16'h0000);
        we = 1'b0;
        rst = 1'b1;
        issue("post_rst_rd", 0, 0, 0, 0, 0, 0, 1, 3,
              16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000);
        issue("post_rst_wr", 1, 1, 16'h0042, 0, 0, 0, 1, 0,
              16'h0042, 16'h0000, 0, 1, 16'h0042, 16'h0000);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register and data port.
REQ-002 Parameter DEPTH, default 8, number of registers; power of two, at least 2.
REQ-003 Parameter ZERO_R0, default 1, when 1 register 0 reads as zero and ignores all updates.
REQ-004 Constant AW = clog2(DEPTH), address width.
REQ-005 The ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- inc_en  in  1  step enable.
- inc_addr  in  AW  step target.
- inc_dec  in  1  step direction: 1 decrement, 0 increment.
- ra_addr  in  AW  read port A address.
- rb_addr  in  AW  read port B address.
- ra_data  out  WIDTH  registered read port A data.
- rb_data  out  WIDTH  registered read port B data.
- wr_conflict  out  1  registered flag: the previous cycle had we and inc_en on the same address.

Function
REQ-006 On each rising clk with we=1, register[waddr] SHALL take wdata.
REQ-007 On each rising clk with inc_en=1, register[inc_addr] SHALL take its current value +1, or -1 when inc_dec=1, modulo 2^WIDTH.
REQ-008 Wrap-around: all-ones +1 SHALL give 0, and 0 -1 SHALL give all-ones, with no flag.
REQ-009 Both enables active with waddr != inc_addr: both updates SHALL occur in the same cycle.
REQ-010 Both enables active with waddr == inc_addr: the write SHALL win, the step SHALL be discarded, and wr_conflict SHALL be 1 in the next cycle; otherwise wr_conflict SHALL be 0.
REQ-011 Reads SHALL have a latency of one cycle: ra_data/rb_data after edge N reflect the addresses sampled at edge N.
REQ-012 Bypass: when a read address equals an address being updated at the same edge, the read port SHALL return the post-update value (the write value, or the stepped value if only a step occurs).
REQ-013 Ports A and B SHALL be independent; equal addresses SHALL return identical data.
REQ-014 ZERO_R0=1: register 0 SHALL never change, and reads of address 0 (including bypass) SHALL return 0; wr_conflict on address 0 SHALL still be reported.
REQ-015 With no enables active, every register SHALL hold its value indefinitely.

Reset
REQ-016 rst=0 SHALL immediately, independent of clk, clear every register, ra_data, rb_data and wr_conflict to 0.
REQ-017 While rst=0, writes and steps SHALL be ignored.
REQ-018 The first edge after rst rises SHALL operate normally.
REQ-019 Reset asserted mid-operation SHALL discard any update pending at that edge.

Structure
REQ-020 A shared package SHALL hold the default WIDTH/DEPTH constants and the step-direction encodings INC=0 and DEC=1.
REQ-021 One sub-module, register_cell, SHALL implement a single WIDTH-bit register with async active-low clear, load enable, and step enable/direction with load priority.
REQ-022 register_file SHALL instantiate DEPTH copies of register_cell, plus address decode, bypass muxing and output registers.

Verification
REQ-023 Reset then read all addresses -> every ra_data/rb_data is 0x0000.
REQ-024 Write r3=0x1234, then read A=3, B=3 -> both outputs 0x1234 one cycle later; same-cycle write r5=0xBEEF with read A=5 -> 0xBEEF (bypass).
REQ-025 Write r2=0xFFFF, then increment r2 -> 0x0000; decrement r2 -> 0xFFFF.
REQ-026 we on r4=0x5678 and inc on r4 in one cycle -> r4=0x5678 and wr_conflict=1 for one cycle; we on r4 and inc on r6 (r6=0x0009) -> r4=0x5678, r6=0x000A, wr_conflict=0.
REQ-027 Write r0=0xDEF0 with ZERO_R0=1 -> reads of r0 return 0x0000; with ZERO_R0=0 -> 0xDEF0.
REQ-028 Load r1=0x9ABC, then drop rst mid-cycle while we is active on r1 -> outputs clear to 0 immediately; r1=0 after rst rises.
